// File: rtl/seq_pattern_gen.sv
// rtl/seq_pattern_gen.sv - serial pattern generator with repeated frames and inter-frame gaps
// Sends a PAT_W-bit pattern MSB first, reps+1 times, with gap idle cycles between frames.
module seq_pattern_gen #(
  parameter int                PAT_W   = 4,
  parameter logic [PAT_W-1:0]  DEF_PAT = PAT_W'(4'b1011)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             pat_sel,
  input  logic [PAT_W-1:0] pattern,
  input  logic [2:0]       reps,
  input  logic [1:0]       gap,
  output logic             j,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int              BW       = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [BW-1:0]   LAST_BIT = BW'(PAT_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state, state_nx;
  logic [PAT_W-1:0] pat_r;
  logic [BW-1:0]    bit_idx;
  logic [2:0]       frames_left;
  logic [1:0]       gap_r;
  logic [1:0]       gap_cnt;
  logic             capture;
  logic             frame_end;

  assign capture   = (state == IDLE) && start && !abort;
  assign frame_end = (bit_idx == '0);

  always_comb begin
    state_nx = state;
    j        = 1'b0;
    valid    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (capture) state_nx = SEND;
      end
      SEND: begin
        j     = pat_r[bit_idx];
        valid = 1'b1;
        busy  = 1'b1;
        if (abort)                   state_nx = IDLE;
        else if (frame_end) begin
          if (frames_left == 3'd0)   state_nx = DONE;
          else if (gap_r != 2'd0)    state_nx = GAP;
          else                       state_nx = SEND;
        end
      end
      GAP: begin
        busy = 1'b1;
        if (abort)                   state_nx = IDLE;
        else if (gap_cnt == 2'd1)    state_nx = SEND;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Counters left mid-frame by abort are harmless: every capture reloads them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      pat_r       <= '0;
      bit_idx     <= '0;
      frames_left <= '0;
      gap_r       <= '0;
      gap_cnt     <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (capture) begin
            pat_r       <= pat_sel ? pattern : DEF_PAT;
            frames_left <= reps;
            gap_r       <= gap;
            bit_idx     <= LAST_BIT;
          end
        end
        SEND: begin
          if (frame_end) begin
            bit_idx <= LAST_BIT;
            gap_cnt <= gap_r;
            if (frames_left != 3'd0) frames_left <= frames_left - 3'd1;
          end else begin
            bit_idx <= bit_idx - BW'(1);
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb/tb_seq_pattern_gen.sv - self-checking bench for seq_pattern_gen against a frame-list model
module tb_seq_pattern_gen;

  localparam int         PAT_W   = 4;
  localparam logic [3:0] DEF_PAT = 4'b1011;
  localparam logic [3:0] IDLE_O  = 4'b0000;   // {j, valid, busy, done}
  localparam logic [3:0] GAP_O   = 4'b0010;
  localparam logic [3:0] DONE_O  = 4'b0011;

  logic       clk = 1'b0;
  logic       rst, start, abort, pat_sel;
  logic [3:0] pattern;
  logic [2:0] reps;
  logic [1:0] gap;
  logic       j, valid, busy, done;

  int total = 0;
  int bad   = 0;
  logic [3:0] expq[$];

  always #5 clk = ~clk;

  seq_pattern_gen #(.PAT_W(PAT_W), .DEF_PAT(DEF_PAT)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .pat_sel(pat_sel),
    .pattern(pattern), .reps(reps), .gap(gap),
    .j(j), .valid(valid), .busy(busy), .done(done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {j, valid, busy, done};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Expected output stream of one whole transmission, frame by frame.
  task automatic build_exp(input logic [3:0] p, input int frames, input int g);
    expq.delete();
    for (int f = 0; f < frames; f++) begin
      for (int b = PAT_W - 1; b >= 0; b--) expq.push_back({p[b], 3'b110});
      if (f < frames - 1) repeat (g) expq.push_back(GAP_O);
    end
    expq.push_back(DONE_O);
  endtask

  task automatic scramble();
    pat_sel = 1'($urandom_range(0, 1));
    pattern = 4'($urandom_range(0, 15));
    reps    = 3'($urandom_range(0, 7));
    gap     = 2'($urandom_range(0, 3));
  endtask

  // Runs one transmission; abort_at < 0 means no abort. Leaves the DUT in IDLE.
  task automatic run_txn(input string tag, input logic sel, input logic [3:0] pat,
                         input logic [2:0] r, input logic [1:0] g,
                         input int abort_at, input bit hold_start);
    pat_sel = sel; pattern = pat; reps = r; gap = g;
    start = 1'b1; abort = 1'b0;
    build_exp(sel ? pat : DEF_PAT, int'(r) + 1, int'(g));
    step();
    for (int i = 0; i < expq.size(); i++) begin
      check(tag, expq[i]);
      if (i == abort_at) begin
        abort = 1'b1;
        start = 1'b0;
        step();
        check({tag, "_abort"}, IDLE_O);
        abort = 1'b0;
        return;
      end
      scramble();
      start = hold_start ? 1'b1 : 1'($urandom_range(0, 1));
      step();
    end
    check({tag, "_idle"}, IDLE_O);
    start = hold_start;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    pat_sel = 1'b0; pattern = 4'h0; reps = 3'd0; gap = 2'd0;
    step();
    step();
    check("reset", IDLE_O);
    rst = 1'b1;
    step();
    check("idle_after_reset", IDLE_O);

    run_txn("def_single", 1'b0, 4'h0, 3'd0, 2'd0, -1, 1'b0);
    run_txn("user_gap2", 1'b1, 4'b0110, 3'd1, 2'd2, -1, 1'b0);
    run_txn("def_rep3_nogap", 1'b0, 4'h5, 3'd2, 2'd0, -1, 1'b0);
    run_txn("max_reps", 1'b1, 4'b1001, 3'd7, 2'd3, -1, 1'b0);
    run_txn("abort_bit3", 1'b0, 4'h0, 3'd1, 2'd0, 2, 1'b0);
    check("abort_quiet", IDLE_O);

    // Reset during GAP, with start held through reset.
    pat_sel = 1'b1; pattern = 4'b0110; reps = 3'd1; gap = 2'd2; start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    check("in_gap", GAP_O);
    rst = 1'b0; start = 1'b1;
    step();
    check("reset_in_gap", IDLE_O);
    step();
    check("start_in_reset", IDLE_O);
    rst = 1'b1; start = 1'b0;
    step();
    check("after_reset", IDLE_O);

    start = 1'b1; abort = 1'b1;
    step();
    check("start_abort_idle", IDLE_O);
    start = 1'b0; abort = 1'b0;
    step();
    check("start_abort_stay", IDLE_O);

    // Start held high: back-to-back transmissions separated by one IDLE cycle.
    run_txn("hold1", 1'b1, 4'b1100, 3'd0, 2'd1, -1, 1'b1);
    run_txn("hold2", 1'b1, 4'b0011, 3'd1, 2'd1, -1, 1'b0);

    for (int t = 0; t < 30; t++) begin
      logic       s;
      logic [3:0] p;
      logic [2:0] r;
      logic [1:0] g;
      int         ab;
      s  = 1'($urandom_range(0, 1));
      p  = 4'($urandom_range(0, 15));
      r  = 3'($urandom_range(0, 7));
      g  = 2'($urandom_range(0, 3));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1;
      run_txn("rand", s, p, r, g, ab, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
